time_counter_bcd: RTL and testbench

- Timekeeping stage that consumes the 1 Hz square wave from the one-second divider.
- Resynchronises that wave into the clk_i domain and detects its rising edge, giving a one-cycle second tick.
- Keeps hours:minutes:seconds in BCD (internally 24 h) and offers a set mode for manual adjustment.
- Presents the time in 12 h or 24 h format to the display/multiplexing logic downstream.

---
 rtl/time_counter_bcd.sv | 105 ++++++++++
 tb/tb_time_counter_bcd.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter_bcd.sv
// BCD hh:mm:ss timekeeper driven by a resynchronised 1 Hz square wave,
// with a set mode for manual adjustment and 12 h / 24 h presentation.
module time_counter_bcd #(
    parameter logic [7:0] RESET_HR  = 8'h00,
    parameter logic [7:0] RESET_MIN = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       sec_clk_i,
    input  logic       set_en_i,
    input  logic       inc_min_i,
    input  logic       inc_hr_i,
    input  logic       mode_24h_i,
    output logic [7:0] sec_o,
    output logic [7:0] min_o,
    output logic [7:0] hr_o,
    output logic       pm_o,
    output logic       tick_o,
    output logic       hour_chime_o,
    output logic       day_wrap_o
);

    // Out-of-range reset values are clamped to 00 so no illegal BCD code can appear.
    localparam logic [7:0] HR_INIT =
        ((RESET_HR[7:4] <= 4'd1 && RESET_HR[3:0] <= 4'd9) ||
         (RESET_HR[7:4] == 4'd2 && RESET_HR[3:0] <= 4'd3)) ? RESET_HR : 8'h00;
    localparam logic [7:0] MIN_INIT =
        (RESET_MIN[7:4] <= 4'd5 && RESET_MIN[3:0] <= 4'd9) ? RESET_MIN : 8'h00;

    logic       s1, s2, s3;
    logic       tick;
    logic [7:0] sec, min, hr24;
    logic [4:0] hr_bin, hr12_bin;
    logic [7:0] hr12;

    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        if (v[3:0] >= 4'd9)
            return {(v[7:4] >= 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hr24(input logic [7:0] v);
        if (v >= 8'h23)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick = s2 & ~s3;

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            sec          <= 8'h00;
            min          <= MIN_INIT;
            hr24         <= HR_INIT;
            tick_o       <= 1'b0;
            hour_chime_o <= 1'b0;
            day_wrap_o   <= 1'b0;
        end else begin
            s1           <= sec_clk_i;
            s2           <= s1;
            s3           <= s2;
            tick_o       <= tick;
            hour_chime_o <= tick && !set_en_i && sec == 8'h59 && min == 8'h59;
            day_wrap_o   <= tick && !set_en_i && sec == 8'h59 && min == 8'h59 && hr24 == 8'h23;
            if (set_en_i) begin
                sec <= 8'h00;
                if (inc_min_i) min  <= inc_mod60(min);
                if (inc_hr_i)  hr24 <= inc_hr24(hr24);
            end else if (tick) begin
                sec <= inc_mod60(sec);
                if (sec == 8'h59) begin
                    min <= inc_mod60(min);
                    if (min == 8'h59) hr24 <= inc_hr24(hr24);
                end
            end
        end
    end

    // 12 h view goes through a small binary hour value and back to BCD.
    always_comb begin
        hr_bin   = 5'(hr24[7:4]) * 5'd10 + 5'(hr24[3:0]);
        hr12_bin = hr_bin;
        if (hr_bin == 5'd0)
            hr12_bin = 5'd12;
        else if (hr_bin > 5'd12)
            hr12_bin = hr_bin - 5'd12;
        if (hr12_bin >= 5'd10)
            hr12 = {4'd1, 4'(hr12_bin - 5'd10)};
        else
            hr12 = {4'd0, 4'(hr12_bin)};
        pm_o = (hr_bin >= 5'd12);
        hr_o = mode_24h_i ? hr24 : hr12;
    end

    assign sec_o = sec;
    assign min_o = min;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Bench for time_counter_bcd: seconds-of-day reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_time_counter_bcd;

    localparam int RH = 23;
    localparam int RM = 59;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic       sec_clk_i = 1'b0;
    logic       set_en_i = 1'b0;
    logic       inc_min_i = 1'b0;
    logic       inc_hr_i = 1'b0;
    logic       mode_24h_i = 1'b1;
    logic [7:0] sec_o, min_o, hr_o;
    logic       pm_o, tick_o, hour_chime_o, day_wrap_o;
    logic [7:0] sec_b, min_b, hr_b;
    logic       pm_b, tick_b, chime_b, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    time_counter_bcd #(.RESET_HR(8'h23), .RESET_MIN(8'h59)) dut (
        .clk_i(clk_i), .reset(reset), .sec_clk_i(sec_clk_i), .set_en_i(set_en_i),
        .inc_min_i(inc_min_i), .inc_hr_i(inc_hr_i), .mode_24h_i(mode_24h_i),
        .sec_o(sec_o), .min_o(min_o), .hr_o(hr_o), .pm_o(pm_o), .tick_o(tick_o),
        .hour_chime_o(hour_chime_o), .day_wrap_o(day_wrap_o)
    );

    time_counter_bcd #(.RESET_HR(8'h2A), .RESET_MIN(8'h7F)) dut_clamp (
        .clk_i(clk_i), .reset(reset), .sec_clk_i(sec_clk_i), .set_en_i(set_en_i),
        .inc_min_i(inc_min_i), .inc_hr_i(inc_hr_i), .mode_24h_i(mode_24h_i),
        .sec_o(sec_b), .min_o(min_b), .hr_o(hr_b), .pm_o(pm_b), .tick_o(tick_b),
        .hour_chime_o(chime_b), .day_wrap_o(wrap_b)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Reference model: time of day as plain seconds, ticks scheduled two
    // edges after the edge that first samples sec_clk_i high.
    int          tod;
    int          mh, mm;
    bit          prev_s;
    bit          tk;
    int unsigned cyc = 0;
    int unsigned due[$];
    bit          e_tick, e_chime, e_wrap;

    always @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            tod = RH * 3600 + RM * 60;
            prev_s = 0;
            due.delete();
            e_tick = 0; e_chime = 0; e_wrap = 0;
        end else begin
            cyc++;
            tk = (due.size() > 0 && due[0] == cyc);
            if (tk) void'(due.pop_front());
            if (sec_clk_i && !prev_s) due.push_back(cyc + 2);
            prev_s = sec_clk_i;
            e_tick = tk; e_chime = 0; e_wrap = 0;
            if (set_en_i) begin
                mh = tod / 3600;
                mm = (tod / 60) % 60;
                if (inc_min_i) mm = (mm + 1) % 60;
                if (inc_hr_i)  mh = (mh + 1) % 24;
                tod = mh * 3600 + mm * 60;
            end else if (tk) begin
                e_chime = (tod % 3600 == 3599);
                e_wrap  = (tod == 86399);
                tod = (tod + 1) % 86400;
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            int h;
            h = tod / 3600;
            chk("sec", sec_o, to_bcd(tod % 60));
            chk("min", min_o, to_bcd((tod / 60) % 60));
            chk("hr", hr_o, mode_24h_i ? to_bcd(h) : to_bcd((h % 12 == 0) ? 12 : h % 12));
            chk("pm", 8'(pm_o), 8'(h >= 12));
            chk("tick", 8'(tick_o), 8'(e_tick));
            chk("chime", 8'(hour_chime_o), 8'(e_chime));
            chk("wrap", 8'(day_wrap_o), 8'(e_wrap));
        end
    end

    task automatic next();
        @(negedge clk_i);
        #1;
    endtask

    task automatic tick_rise();
        next();
        sec_clk_i = 1'b1;
        repeat (3) next();
    endtask

    task automatic tick_fall();
        sec_clk_i = 1'b0;
        repeat (3) next();
    endtask

    task automatic full_ticks(input int n);
        repeat (n) begin
            tick_rise();
            tick_fall();
        end
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            next(); inc_min_i = 1'b1;
            next(); inc_min_i = 1'b0;
        end
    endtask

    task automatic pulse_hr(input int n);
        repeat (n) begin
            next(); inc_hr_i = 1'b1;
            next(); inc_hr_i = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hc;
        #3 reset = 1'b0;
        cmp_en = 1;
        repeat (3) next();
        chk("rst_hr_clamp", hr_b, 8'h00);
        chk("rst_min_clamp", min_b, 8'h00);
        reset = 1'b1;
        next();
        chk("rst_sec", sec_o, 8'h00);
        chk("rst_min", min_o, 8'h59);
        chk("rst_hr", hr_o, 8'h23);
        chk("rst_tick", 8'(tick_o), 8'h00);

        // 23:59:59 -> 00:00:00 with latency pinned
        full_ticks(59);
        chk("pre_wrap_sec", sec_o, 8'h59);
        next(); sec_clk_i = 1'b1;
        next(); next();
        chk("lat_edge2_sec", sec_o, 8'h59);
        chk("lat_edge2_tick", 8'(tick_o), 8'h00);
        next();
        chk("wrap_sec", sec_o, 8'h00);
        chk("wrap_min", min_o, 8'h00);
        chk("wrap_hr", hr_o, 8'h00);
        chk("wrap_tick", 8'(tick_o), 8'h01);
        chk("wrap_chime", 8'(hour_chime_o), 8'h01);
        chk("wrap_day", 8'(day_wrap_o), 8'h01);
        next();
        chk("wrap_tick_end", 8'(tick_o), 8'h00);
        chk("wrap_chime_end", 8'(hour_chime_o), 8'h00);
        chk("wrap_day_end", 8'(day_wrap_o), 8'h00);
        tick_fall();

        // 09:59:59 -> 10:00:00
        set_en_i = 1'b1;
        pulse_hr(9);
        pulse_min(59);
        set_en_i = 1'b0;
        full_ticks(59);
        chk("h9_sec", sec_o, 8'h59);
        chk("h9_min", min_o, 8'h59);
        tick_rise();
        chk("h10_hr", hr_o, 8'h10);
        chk("h10_min", min_o, 8'h00);
        chk("h10_sec", sec_o, 8'h00);
        chk("h10_chime", 8'(hour_chime_o), 8'h01);
        chk("h10_wrap", 8'(day_wrap_o), 8'h00);
        tick_fall();

        // set mode at 10:15:42
        set_en_i = 1'b1;
        pulse_min(15);
        set_en_i = 1'b0;
        full_ticks(42);
        chk("s42_sec", sec_o, 8'h42);
        set_en_i = 1'b1;
        next();
        chk("set_sec_zero", sec_o, 8'h00);
        repeat (45) begin
            next(); inc_min_i = 1'b1; sec_clk_i = ~sec_clk_i;
            next(); inc_min_i = 1'b0; sec_clk_i = ~sec_clk_i;
        end
        chk("set_min45", min_o, 8'h00);
        chk("set_hr_keep", hr_o, 8'h10);
        repeat (14) begin
            next(); inc_hr_i = 1'b1; sec_clk_i = ~sec_clk_i;
            next(); inc_hr_i = 1'b0; sec_clk_i = ~sec_clk_i;
        end
        chk("set_hr14", hr_o, 8'h00);
        chk("set_chime", 8'(hour_chime_o), 8'h00);

        // 12 h presentation sweep
        mode_24h_i = 1'b0;
        next();
        chk("h12_00", hr_o, 8'h12); chk("pm_00", 8'(pm_o), 8'h00);
        pulse_hr(11);
        chk("h12_11", hr_o, 8'h11); chk("pm_11", 8'(pm_o), 8'h00);
        pulse_hr(1);
        chk("h12_12", hr_o, 8'h12); chk("pm_12", 8'(pm_o), 8'h01);
        pulse_hr(1);
        chk("h12_13", hr_o, 8'h01); chk("pm_13", 8'(pm_o), 8'h01);
        pulse_hr(10);
        chk("h12_23", hr_o, 8'h11); chk("pm_23", 8'(pm_o), 8'h01);
        mode_24h_i = 1'b1;
        next();
        chk("h24_23", hr_o, 8'h23);

        // simultaneous increments at 23:59, then in run mode
        pulse_min(59);
        next(); inc_min_i = 1'b1; inc_hr_i = 1'b1;
        next(); inc_min_i = 1'b0; inc_hr_i = 1'b0;
        chk("both_min", min_o, 8'h00);
        chk("both_hr", hr_o, 8'h00);
        set_en_i = 1'b0;
        tick_fall();
        next(); inc_min_i = 1'b1; inc_hr_i = 1'b1;
        next(); inc_min_i = 1'b0; inc_hr_i = 1'b0;
        chk("run_inc_min", min_o, 8'h00);
        chk("run_inc_hr", hr_o, 8'h00);
        chk("run_inc_sec", sec_o, 8'h00);

        // reset with an edge in flight
        next(); sec_clk_i = 1'b1;
        next(); next();
        reset = 1'b0; sec_clk_i = 1'b0;
        repeat (2) next();
        reset = 1'b1;
        repeat (3) next();
        chk("rst_mid_sec", sec_o, 8'h00);
        chk("rst_mid_min", min_o, 8'h59);
        chk("rst_mid_hr", hr_o, 8'h23);
        tick_rise();
        chk("rst_mid_first", sec_o, 8'h01);
        tick_fall();

        // random run-only phase (crosses 23:59:59), then mixed
        hc = 1;
        for (int i = 0; i < 5000; i++) begin
            next();
            inc_min_i = ($urandom_range(0, 7) == 0);
            inc_hr_i  = ($urandom_range(0, 7) == 0);
            if (i >= 1500 && $urandom_range(0, 149) == 0) set_en_i = ~set_en_i;
            if ($urandom_range(0, 99) == 0) mode_24h_i = ~mode_24h_i;
            if (hc == 0) begin
                sec_clk_i = ~sec_clk_i;
                hc = $urandom_range(0, 3);
            end else begin
                hc--;
            end
        end
        inc_min_i = 1'b0; inc_hr_i = 1'b0;
        repeat (4) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
